// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC sequencer, imem request issue and instruction FIFO with redirect flush
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic        redirect_type,
    input  logic [31:0] redirect_base,
    input  logic [15:0] redirect_offset,
    input  logic [25:0] redirect_imme,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    logic          pop;
    logic [CW:0]   occupancy;
    logic [31:0]   branch_target;
    logic [31:0]   jump_target;
    logic [31:0]   target;

    assign instr_valid = (count != '0);
    assign instr_out   = word_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign imem_addr   = fetch_pc;
    assign pop         = instr_valid & instr_ready;

    // Counting the pop lets a full-rate stream keep one request in flight at DEPTH=2
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req  = rst_n & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));

    assign branch_target = redirect_base + {{14{redirect_offset[15]}}, redirect_offset, 2'b00};
    assign jump_target   = {redirect_base[31:28], redirect_imme, 2'b00};
    assign target        = redirect_type ? jump_target : branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: queued words and the in-flight response are all stale
            fetch_pc <= target;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (inflight) begin
                pc_mem[wr_ptr]   <= req_pc;
                word_mem[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(inflight) - CW'(pop);
        end
    end
endmodule
